// File: rtl/booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_pp_accumulator
// Purpose  : Pipelined partial-product summation stage of the 8-bit radix-4
//            Booth multiplier. Accepts four 9-bit signed partial products per
//            beat, weights them by 4^i, sign-extends and sums them into a
//            16-bit signed product over a 2-stage registered adder tree.
//            Valid/ready handshake on both sides, full throughput.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - pp0..pp3 hold a valid set
//            in_ready   - stage can accept a set this cycle
//            pp0..pp3   - partial products, digit i has weight 4^i
//            out_valid  - product valid
//            out_ready  - consumer accepts product
//            product    - signed product (modulo 2^16)
//            in_tag/out_tag - 4-bit sideband tag (BOOTH_ACC_TAG_EN only)
// Options  : BOOTH_ACC_TAG_EN - adds the sideband tag carried with each set
// Revision : 1.0 - initial release
// ============================================================================
module booth_pp_accumulator #(
   parameter int PP_W = 9,
   parameter int P_W  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PP_W-1:0] pp0,
   input  logic [PP_W-1:0] pp1,
   input  logic [PP_W-1:0] pp2,
   input  logic [PP_W-1:0] pp3,
`ifdef BOOTH_ACC_TAG_EN
   input  logic [3:0]      in_tag,
   output logic [3:0]      out_tag,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [P_W-1:0]  product
);

   localparam int c_EXT_W = P_W - PP_W;

   // Sign-extended partial products
   logic [P_W-1:0] w_sx0;
   logic [P_W-1:0] w_sx1;
   logic [P_W-1:0] w_sx2;
   logic [P_W-1:0] w_sx3;

   // First-level sums feeding stage 1
   logic [P_W-1:0] w_s01;
   logic [P_W-1:0] w_s23;

   // Handshake
   logic           w_adv1;
   logic           w_adv2;

   // Pipeline registers
   logic [P_W-1:0] r_s01;
   logic [P_W-1:0] r_s23;
   logic           r_v1;
   logic [P_W-1:0] r_product;
   logic           r_v2;

   assign w_sx0 = {{c_EXT_W{pp0[PP_W-1]}}, pp0};
   assign w_sx1 = {{c_EXT_W{pp1[PP_W-1]}}, pp1};
   assign w_sx2 = {{c_EXT_W{pp2[PP_W-1]}}, pp2};
   assign w_sx3 = {{c_EXT_W{pp3[PP_W-1]}}, pp3};

   // Pairwise combine: digit pairs differ by a factor of 4 (shift by 2)
   assign w_s01 = w_sx0 + (w_sx1 << 2);
   assign w_s23 = w_sx2 + (w_sx3 << 2);

   // Stage 2 drains when its slot is empty or being consumed; stage 1 can
   // then take a new set even while full, giving one set per cycle.
   assign w_adv2   = r_v1 && (!r_v2 || out_ready);
   assign in_ready = !r_v1 || w_adv2;
   assign w_adv1   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s01     <= '0;
         r_s23     <= '0;
         r_v1      <= 1'b0;
         r_product <= '0;
         r_v2      <= 1'b0;
      end else begin
         if (w_adv1) begin
            r_s01 <= w_s01;
            r_s23 <= w_s23;
         end
         r_v1 <= w_adv1 ? 1'b1 : (w_adv2 ? 1'b0 : r_v1);

         // Upper pair carries weight 4^2 relative to the lower pair
         if (w_adv2) begin
            r_product <= r_s01 + (r_s23 << 4);
         end
         r_v2 <= w_adv2 ? 1'b1 : (out_ready ? 1'b0 : r_v2);
      end
   end

`ifdef BOOTH_ACC_TAG_EN
   // Tag follows the same load/hold rules as the data it belongs to
   logic [3:0] r_tag1;
   logic [3:0] r_tag2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag1 <= 4'h0;
         r_tag2 <= 4'h0;
      end else begin
         if (w_adv1) begin
            r_tag1 <= in_tag;
         end
         if (w_adv2) begin
            r_tag2 <= r_tag1;
         end
      end
   end

   assign out_tag = r_tag2;
`endif

   assign out_valid = r_v2;
   assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_pp_accumulator
// Purpose  : Scoreboard bench for booth_pp_accumulator. Directed partial
//            product sets with hand-computed products are queued on accept;
//            a monitor pops and compares on every output handshake and
//            checks that a stalled output holds steady.
// Options  : BOOTH_ACC_TAG_EN - also connects and checks the sideband tag
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_pp_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  pp0;
   logic [8:0]  pp1;
   logic [8:0]  pp2;
   logic [8:0]  pp3;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic [3:0]  in_tag;
   logic [3:0]  out_tag;

   typedef struct packed {
      logic [15:0] prod;
      logic [3:0]  tag;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   booth_pp_accumulator #(.PP_W(9), .P_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pp0       (pp0),
      .pp1       (pp1),
      .pp2       (pp2),
      .pp3       (pp3),
`ifdef BOOTH_ACC_TAG_EN
      .in_tag    (in_tag),
      .out_tag   (out_tag),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

`ifndef BOOTH_ACC_TAG_EN
   assign out_tag = 4'h0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed vectors: pp0, pp1, pp2, pp3, expected product
   logic [8:0]  v_pp [8][4];
   logic [15:0] v_exp[8];

   initial begin
      v_pp[0] = '{9'h1FB, 9'h005, 9'h000, 9'h000}; v_exp[0] = 16'h000F; // 5*3
      v_pp[1] = '{9'h181, 9'h000, 9'h000, 9'h0FE}; v_exp[1] = 16'h3F01; // 127*127
      v_pp[2] = '{9'h00E, 9'h000, 9'h000, 9'h000}; v_exp[2] = 16'h000E; // -7*-2
      v_pp[3] = '{9'h1F9, 9'h000, 9'h000, 9'h000}; v_exp[3] = 16'hFFF9; // -7*1
      v_pp[4] = '{9'h000, 9'h000, 9'h000, 9'h1FF}; v_exp[4] = 16'hFFC0; // -1*64
      v_pp[5] = '{9'h100, 9'h100, 9'h100, 9'h100}; v_exp[5] = 16'hAB00; // -256*85
      v_pp[6] = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF}; v_exp[6] = 16'h54AB; // 255*85
      v_pp[7] = '{9'h001, 9'h001, 9'h001, 9'h001}; v_exp[7] = 16'h0055; // 1*85
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Called at posedge+1; presents a set and waits until it is accepted.
   task automatic send(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                       input logic [8:0] d, input logic [3:0] t, input logic [15:0] e,
                       output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      pp0 = a; pp1 = b; pp2 = c; pp3 = d; in_tag = t;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{prod: e, tag: t});
            done = 1'b1;
         end else begin
            waited++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on every output handshake, verify stall stability
   logic        prev_stall = 1'b0;
   logic [15:0] prev_prod  = 16'h0;
   logic [3:0]  prev_tag   = 4'h0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", out_valid, 1);
               check("hold_product", product, prev_prod);
`ifdef BOOTH_ACC_TAG_EN
               check("hold_tag", out_tag, prev_tag);
`endif
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: product %h with empty scoreboard", product);
               end else begin
                  e = sb.pop_front();
                  check("product", product, e.prod);
`ifdef BOOTH_ACC_TAG_EN
                  check("out_tag", out_tag, e.tag);
`endif
                  n_out++;
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_prod  = product;
            prev_tag   = out_tag;
         end
      end
   end

   initial begin
      int w;
      int base;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      pp0 = '0; pp1 = '0; pp2 = '0; pp3 = '0;
      in_tag = 4'h0;

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 16'h0000);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_tag", out_tag, 4'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      // Single beat latency: nothing after edge N, product after edge N+1
      send(v_pp[0][0], v_pp[0][1], v_pp[0][2], v_pp[0][3], 4'h1, v_exp[0], w);
      @(negedge clk);
      check("latency_early", out_valid, 0);
      @(negedge clk);
      check("latency_valid", out_valid, 1);
      @(posedge clk);
      #1;

      for (int i = 1; i < 4; i++) begin
         send(v_pp[i][0], v_pp[i][1], v_pp[i][2], v_pp[i][3], 4'(i + 1), v_exp[i], w);
         repeat (3) @(posedge clk);
         #1;
      end
      drain();

      // Back-to-back streaming, tags 1..8
      base = n_out;
      for (int i = 0; i < 8; i++) begin
         send(v_pp[i][0], v_pp[i][1], v_pp[i][2], v_pp[i][3], 4'(i + 1), v_exp[i], w);
         check("stream_in_ready", w, 0);
      end
      drain();
      check("stream_count", n_out - base, 8);

      // Back-pressure: two sets fit, third blocks until output drains
      base = n_out;
      out_ready = 1'b0;
      send(v_pp[5][0], v_pp[5][1], v_pp[5][2], v_pp[5][3], 4'h6, v_exp[5], w);
      check("bp_first_wait", w, 0);
      send(v_pp[6][0], v_pp[6][1], v_pp[6][2], v_pp[6][3], 4'h7, v_exp[6], w);
      check("bp_second_wait", w, 0);
      pp0 = v_pp[7][0]; pp1 = v_pp[7][1]; pp2 = v_pp[7][2]; pp3 = v_pp[7][3];
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(v_pp[7][0], v_pp[7][1], v_pp[7][2], v_pp[7][3], 4'h8, v_exp[7], w);
      drain();
      check("bp_count", n_out - base, 3);

      // Reset with both stages full discards everything
      out_ready = 1'b0;
      send(v_pp[1][0], v_pp[1][1], v_pp[1][2], v_pp[1][3], 4'h9, v_exp[1], w);
      send(v_pp[2][0], v_pp[2][1], v_pp[2][2], v_pp[2][3], 4'hA, v_exp[2], w);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_product", product, 16'h0000);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_tag", out_tag, 4'h0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_mid_rst_idle", out_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
